// File: rtl/nios2_mult_pipe_cell.sv
// Three-stage pipelined multiplier cell for MUL/MULXUU/MULXSU/MULXSS.
// Four unsigned half-width partial products are summed and then sign-corrected to form a 2W-bit product.
module nios2_mult_pipe_cell #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  input  logic [1:0]     op,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   result,
  output logic [2*W-1:0] product
);

  localparam int HALF = W / 2;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // Stage 1 operand registers
  logic [W-1:0] a1, b1;
  logic [1:0]   op1;
  logic         v1;

  // Stage 2 partial products and sign flags
  logic [W-1:0] pll, plh, phl, phh;
  logic [W-1:0] a2, b2;
  logic [1:0]   op2;
  logic         v2, a_neg2, b_neg2;

  // Zero-extended halves so each product is computed at full W width
  logic [W-1:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;
  logic [2*W-1:0] uu, corr, prod_next;

  assign in_ready = en;

  assign a_lo_x = {{HALF{1'b0}}, a1[HALF-1:0]};
  assign a_hi_x = {{HALF{1'b0}}, a1[W-1:HALF]};
  assign b_lo_x = {{HALF{1'b0}}, b1[HALF-1:0]};
  assign b_hi_x = {{HALF{1'b0}}, b1[W-1:HALF]};

  // NOTE: state is updated with non-blocking assignments so every stage samples the previous stage's old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
      v1  <= 1'b0;
    end else if (en) begin
      a1  <= src1;
      b1  <= src2;
      op1 <= op;
      v1  <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pll    <= '0;
      plh    <= '0;
      phl    <= '0;
      phh    <= '0;
      a2     <= '0;
      b2     <= '0;
      op2    <= '0;
      v2     <= 1'b0;
      a_neg2 <= 1'b0;
      b_neg2 <= 1'b0;
    end else if (en) begin
      pll    <= a_lo_x * b_lo_x;
      plh    <= a_lo_x * b_hi_x;
      phl    <= a_hi_x * b_lo_x;
      phh    <= a_hi_x * b_hi_x;
      a2     <= a1;
      b2     <= b1;
      op2    <= op1;
      v2     <= v1;
      a_neg2 <= a1[W-1] & op1[1];
      b_neg2 <= b1[W-1] & (op1 == OP_MULXSS);
    end
  end

  // Signed operands are treated as unsigned, then each negative operand's weight 2^W*other is removed.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    uu        = '0;
    corr      = '0;
    prod_next = '0;
    uu = {{W{1'b0}}, pll}
       + ({{W{1'b0}}, plh} << HALF)
       + ({{W{1'b0}}, phl} << HALF)
       + {phh, {W{1'b0}}};
    if (a_neg2) corr = corr + {b2, {W{1'b0}}};
    if (b_neg2) corr = corr + {a2, {W{1'b0}}};
    prod_next = uu - corr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      product   <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      product   <= prod_next;
      result    <= (op2 == OP_MUL) ? prod_next[W-1:0] : prod_next[2*W-1:W];
      out_valid <= v2;
    end
  end

endmodule

// File: tb/tb_nios2_mult_pipe_cell.sv
// Scoreboard bench for nios2_mult_pipe_cell: the driver queues one expected output per enabled edge,
// and a negedge monitor pops and compares, also checking that outputs hold during stalls and clear on reset.
module tb_nios2_mult_pipe_cell;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic [63:0] prod;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, en, in_valid;
  logic [31:0] src1, src2;
  logic [1:0]  op;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [63:0] product;

  exp_t sb[$];
  exp_t cur;
  logic en_q = 1'b0, rst_q = 1'b0;
  bit   started = 1'b0;
  int   checks = 0, failures = 0;
  int   issued = 0, seen = 0;

  nios2_mult_pipe_cell #(.W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .in_valid (in_valid),
    .src1     (src1),
    .src2     (src2),
    .op       (op),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .result   (result),
    .product  (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_q  <= en;
    rst_q <= reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sign- or zero-extend each operand to 64 bits and multiply.
  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_v;
    sa   = o[1]        ? longint'($signed(a)) : longint'({32'b0, a});
    sb_v = (o == 2'b11) ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(sa * sb_v);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", {63'b0, in_ready}, {63'b0, en});
      if (rst_q) begin
        cur = '0;
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_result", {32'b0, result}, 64'd0);
        check("reset_product", product, 64'd0);
      end else if (en_q) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: output edge with no expected entry at %0t", $time);
        end else begin
          cur = sb.pop_front();
          check("out_valid", {63'b0, out_valid}, {63'b0, cur.v});
          if (cur.v) begin
            check("result", {32'b0, result}, {32'b0, cur.res});
            check("product", product, cur.prod);
          end
          if (out_valid) seen++;
        end
      end else begin
        check("stall_out_valid", {63'b0, out_valid}, {63'b0, cur.v});
        if (cur.v) begin
          check("stall_result", {32'b0, result}, {32'b0, cur.res});
          check("stall_product", product, cur.prod);
        end
      end
    end
  end

  task automatic step(input logic rst_i, input logic en_i, input logic v_i, input logic [1:0] op_i,
                      input logic [31:0] a_i, input logic [31:0] b_i,
                      input logic known, input logic [31:0] kres, input logic [63:0] kprod);
    exp_t e;
    logic [63:0] p;
    reset    = rst_i;
    en       = en_i;
    in_valid = v_i;
    op       = op_i;
    src1     = a_i;
    src2     = b_i;
    @(posedge clk);
    if (rst_i) begin
      foreach (sb[i]) if (sb[i].v) issued--;
      sb.delete();
      sb.push_back('0);
      sb.push_back('0);
      started = 1'b1;
    end else if (en_i) begin
      e = '0;
      e.v = v_i;
      if (known) begin
        e.res  = kres;
        e.prod = kprod;
      end else begin
        p      = ref_prod(op_i, a_i, b_i);
        e.prod = p;
        e.res  = (op_i == 2'b00) ? p[31:0] : p[63:32];
      end
      sb.push_back(e);
      if (v_i) issued++;
    end
    #1;
  endtask

  task automatic do_reset(input logic en_i);
    step(1'b1, en_i, 1'b1, $urandom_range(0, 3), $urandom, $urandom, 1'b0, '0, '0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, 1'b1, o, a, b, 1'b0, '0, '0);
  endtask

  task automatic issue_k(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [63:0] p);
    step(1'b0, 1'b1, 1'b1, o, a, b, 1'b1, r, p);
  endtask

  task automatic bubble();
    step(1'b0, 1'b1, 1'b0, $urandom_range(0, 3), $urandom, $urandom, 1'b0, '0, '0);
  endtask

  task automatic stall();
    step(1'b0, 1'b0, 1'b1, $urandom_range(0, 3), $urandom, $urandom, 1'b0, '0, '0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    #1;
    do_reset(1'b1);
    do_reset(1'b0);

    // Directed cases with hand-computed results; bubbles between show the latency.
    issue_k(2'b00, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    bubble();
    bubble();
    issue_k(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
    issue_k(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0001);
    issue_k(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 64'h4000_0000_0000_0000);
    issue_k(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
    issue_k(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 64'h8000_0000_8000_0000);
    bubble();
    bubble();

    // Three back-to-back ops with a two-cycle stall while in flight.
    issue(2'b11, 32'h1234_5678, 32'h9ABC_DEF0);
    issue(2'b00, 32'hDEAD_BEEF, 32'h0000_0003);
    issue(2'b10, 32'hF000_0001, 32'h8765_4321);
    stall();
    stall();
    bubble();
    bubble();
    bubble();

    // Reset with three ops in flight, asserted while en is low to show reset wins.
    issue(2'b01, 32'hCAFE_0001, 32'h0000_0002);
    issue(2'b11, 32'h8000_0001, 32'h7FFF_FFFF);
    issue(2'b10, 32'hFFFF_0000, 32'h0001_FFFF);
    do_reset(1'b0);
    bubble();
    bubble();
    bubble();

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (i == 200) do_reset(1'b1);
      else if (r < 2) stall();
      else if (r < 3) bubble();
      else issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
    end

    bubble();
    bubble();
    bubble();
    @(negedge clk);
    #1;
    check("valid_count", 64'(seen), 64'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
